// File: rtl/rx_ts_inserter.sv
// Receive-side timestamp inserter: stamps each packet with count64 at SOP acceptance
// and emits that stamp as an extra header word (ctrl=TS_CTRL) ahead of the packet.
module rx_ts_inserter #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] TS_CTRL = CTRL_WIDTH'(8'hFE),
    parameter int unsigned FIFO_ADDR_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [63:0]           count64,
    input  logic                  ts_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  pkt_stamped
);

    localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int unsigned CNT_W = FIFO_ADDR_BITS + 1;
    localparam int unsigned TS_W  = 64;

    typedef struct packed {
        logic                  sop;
        logic                  ins;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        HDR      = 2'd1,
        DATA     = 2'd2
    } in_state_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        STAMPED = 2'd2
    } out_state_e;

    entry_t                    mem_q [DEPTH];
    logic [TS_W-1:0]           ts_q  [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      in_rdy_q, in_rdy_d;
    in_state_e                 in_state_q, in_state_d;
    out_state_e                out_state_q, out_state_d;

    logic   push;
    logic   pop;
    logic   empty;
    logic   stamp_now;
    entry_t head;
    entry_t wr_entry;

    assign push      = in_wr && in_rdy_q;
    assign empty     = (cnt_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign stamp_now = !empty && head.sop && head.ins && (out_state_q != STAMPED);
    assign pop       = out_rdy && !empty && !stamp_now;
    assign in_rdy    = in_rdy_q;

    // SOP entries carry the per-packet insertion decision
    always_comb begin
        wr_entry      = '0;
        wr_entry.sop  = (in_state_q == WAIT_SOP);
        wr_entry.ins  = (in_state_q == WAIT_SOP) && ts_en;
        wr_entry.ctrl = in_ctrl;
        wr_entry.data = in_data;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_ADDR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_BITS'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        in_rdy_d = (cnt_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
            ts_q[wr_ptr_q]  <= count64;
        end
    end

    // Input packet tracker
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            in_state_q <= WAIT_SOP;
        end else begin
            in_state_q <= in_state_d;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        if (push) begin
            case (in_state_q)
                WAIT_SOP: in_state_d = (in_ctrl != '0) ? HDR : DATA;
                HDR:      if (in_ctrl == '0) in_state_d = DATA;
                DATA:     if (in_ctrl != '0) in_state_d = WAIT_SOP;
                default:  in_state_d = WAIT_SOP;
            endcase
        end
    end

    // Output FSM: STAMPED holds the SOP word at the head until it is sent
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_state_q <= IDLE;
        end else begin
            out_state_q <= out_state_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            STAMPED: begin
                if (out_rdy) begin
                    out_state_d = BODY;
                end
            end
            default: begin
                if (out_rdy && stamp_now) begin
                    out_state_d = STAMPED;
                end else if (empty) begin
                    out_state_d = IDLE;
                end else begin
                    out_state_d = BODY;
                end
            end
        endcase
    end

    always_comb begin
        out_wr      = 1'b0;
        out_data    = '0;
        out_ctrl    = '0;
        pkt_stamped = 1'b0;
        if (!empty) begin
            out_wr = out_rdy;
            if (stamp_now) begin
                out_ctrl    = TS_CTRL;
                out_data    = DATA_WIDTH'(ts_q[rd_ptr_q]);
                pkt_stamped = out_rdy;
            end else begin
                out_ctrl = head.ctrl;
                out_data = head.data;
            end
        end
    end

endmodule

// File: tb/tb_rx_ts_inserter.sv
// Scoreboard bench for rx_ts_inserter: a packet-level model predicts the output stream
// at input acceptance; an independent monitor compares every transferred output word.
module tb_rx_ts_inserter;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic        stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [63:0] count64;
    logic        ts_en;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        pkt_stamped;

    logic [63:0] cyc = 64'd0;
    logic [63:0] ts_base;
    int          rdy_mode;
    exp_t        sb[$];
    int          n_vec;
    int          n_err;
    bit          m_at_sop;
    bit          m_seen_data;

    rx_ts_inserter dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .count64    (count64),
        .ts_en      (ts_en),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .pkt_stamped(pkt_stamped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;
    assign count64 = ts_base + cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Packet-level reference: SOP is the first word after an EOP, EOP is a
    // non-zero ctrl word seen after at least one zero-ctrl word.
    task automatic model_accept(input logic [7:0] c, input logic [63:0] d, input logic [63:0] ts);
        exp_t e;
        if (m_at_sop) begin
            if (ts_en) begin
                e.ctrl = 8'hFE; e.data = ts; e.stamp = 1'b1;
                sb.push_back(e);
            end
            m_at_sop    = 1'b0;
            m_seen_data = (c == 8'h00);
        end else if (c == 8'h00) begin
            m_seen_data = 1'b1;
        end else if (m_seen_data) begin
            m_at_sop = 1'b1;
        end
        e.ctrl = c; e.data = d; e.stamp = 1'b0;
        sb.push_back(e);
    endtask

    task automatic drive_word(input logic [7:0] c, input logic [63:0] d);
        bit acc = 1'b0;
        in_wr = 1'b1; in_ctrl = c; in_data = d;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            if (in_rdy) begin
                model_accept(c, d, count64);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_wr = 1'b0;
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: word %0h never accepted, want accepted", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin @(negedge clk); k++; end
        check("drain_empty", 64'(sb.size()), 64'd0);
        idle(2);
    endtask

    task automatic send_pkt(input int nhdr, input int ndata, input logic [63:0] base);
        for (int i = 0; i < nhdr; i++) drive_word(8'($urandom_range(1, 255)), base + 64'(i));
        for (int i = 0; i < ndata; i++) drive_word(8'h00, base + 64'(nhdr + i));
        drive_word(8'($urandom_range(1, 255)), base + 64'(nhdr + ndata));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_L && out_wr) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_out: got ctrl=%h data=%h, want no output", out_ctrl, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_ctrl !== e.ctrl || out_data !== e.data || pkt_stamped !== e.stamp) begin
                        n_err++;
                        $display("FAIL out_word: got ctrl=%h data=%h stamp=%b, want ctrl=%h data=%h stamp=%b",
                                 out_ctrl, out_data, pkt_stamped, e.ctrl, e.data, e.stamp);
                    end
                end
            end else if (pkt_stamped) begin
                n_vec++; n_err++;
                $display("FAIL stray_stamp: got pkt_stamped=1 without out_wr, want 0");
            end
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_rdy = 1'b0;
                1:       out_rdy = 1'b1;
                default: out_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    initial begin
        reset_L = 1'b0; ts_en = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0;
        out_rdy = 1'b0; ts_base = 64'd0; rdy_mode = 1;
        n_vec = 0; n_err = 0; m_at_sop = 1'b1; m_seen_data = 1'b0;
        fork
            monitor();
            rdy_driver();
        join_none

        // Reset values and in_rdy rising on the first edge after release
        repeat (3) @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_pkt_stamped", 64'(pkt_stamped), 64'd0);
        @(posedge clk); #1; reset_L = 1'b1;
        @(negedge clk);
        check("in_rdy_before_edge", 64'(in_rdy), 64'd0);
        @(negedge clk);
        check("in_rdy_after_edge", 64'(in_rdy), 64'd1);
        @(posedge clk); #1;

        // 8-word stamped packet with count64=1000 at SOP
        ts_en = 1'b1;
        ts_base = 64'd1000 - cyc;
        for (int i = 1; i <= 8; i++) drive_word((i == 8) ? 8'h80 : 8'h00, 64'(i));
        drain();

        // Same packet unstamped
        ts_en = 1'b0;
        for (int i = 1; i <= 8; i++) drive_word((i == 8) ? 8'h80 : 8'h00, 64'(i));
        drain();

        // Back-to-back 2-word packets, SOPs at count64 50 and 52
        ts_en = 1'b1;
        ts_base = 64'd50 - cyc;
        drive_word(8'h00, 64'hA1); drive_word(8'h01, 64'hA2);
        drive_word(8'h00, 64'hB1); drive_word(8'h01, 64'hB2);
        drain();

        // Module-header packet: stamp precedes the FF word
        drive_word(8'hFF, 64'hC0); drive_word(8'h00, 64'hC1);
        drive_word(8'h00, 64'hC2); drive_word(8'h04, 64'hC3);
        drain();

        // Backpressure: in_rdy drops after 4 accepts, recovers the cycle after the first pop
        ts_en = 1'b0; rdy_mode = 0; idle(2);
        for (int i = 0; i < 4; i++) drive_word(8'h00, 64'hD0 + 64'(i));
        fork
            drive_word(8'h80, 64'hD4);
            begin
                int k = 0;
                repeat (2) @(negedge clk);
                check("full_in_rdy", 64'(in_rdy), 64'd0);
                check("full_hold_out_wr", 64'(out_wr), 64'd0);
                rdy_mode = 1;
                do begin @(negedge clk); k++; end while (!out_wr && k < 20);
                check("first_pop_seen", 64'(out_wr), 64'd1);
                @(negedge clk);
                check("in_rdy_reassert", 64'(in_rdy), 64'd1);
            end
        join
        drain();

        // Reset mid-packet with 3 words buffered
        ts_en = 1'b1; rdy_mode = 0; idle(2);
        drive_word(8'h00, 64'hE0); drive_word(8'h00, 64'hE1); drive_word(8'h00, 64'hE2);
        reset_L = 1'b0;
        #1;
        check("midrst_out_wr", 64'(out_wr), 64'd0);
        check("midrst_in_rdy", 64'(in_rdy), 64'd0);
        sb.delete(); m_at_sop = 1'b1; m_seen_data = 1'b0;
        rdy_mode = 1; idle(2);
        reset_L = 1'b1; idle(2);
        ts_base = 64'h1234_0000 - cyc;
        drive_word(8'h00, 64'hF0); drive_word(8'h02, 64'hF1);
        drain();

        // Randomized packets, random ts_en, gaps and out_rdy
        rdy_mode = 2;
        ts_base = {$urandom, $urandom};
        for (int p = 0; p < 40; p++) begin
            ts_en = 1'($urandom_range(0, 1));
            send_pkt($urandom_range(0, 2), $urandom_range(1, 5), 64'(p) << 8);
            idle($urandom_range(0, 2));
        end
        rdy_mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
